// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, FSM state type and baud divisor helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic LINE_IDLE = 1'b1;

    function automatic int unsigned baud_div(input int unsigned clk_frq,
                                             input int unsigned baud_rate);
        return clk_frq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Restartable bit-period counter: o_tick pulses for one cycle every N clocks,
// counting from the cycle after a synchronous i_restart.
module uart_baud_gen #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 4
) (
    input  logic i_clk,
    input  logic i_areset,
    input  logic i_restart,
    output logic o_tick
);

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = (r_cnt == W'(N - 1));
    assign o_tick = w_last;

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_cnt <= '0;
        end else if (i_restart || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, BYTE data bits LSB first, STOP_BITS stop bits,
// with a one-entry holding register so frames go out back to back.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FRQ   = 250000000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned BYTE      = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            tx_valid,
    input  logic [BYTE-1:0] tx_data,
    output logic            tx_ready,
    output logic            data_out,
    output logic            tx_busy
);

    localparam int unsigned BAUD_DIV = baud_div(CLK_FRQ, BAUD_RATE);
    localparam int unsigned CW_RAW   = $clog2(STOP_BITS * BAUD_DIV);
    localparam int unsigned CW       = (CW_RAW > 0) ? CW_RAW : 1;
    localparam int unsigned BW       = $clog2(BYTE) + 1;
    localparam logic [BW-1:0] LAST_DATA = BW'(BYTE - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    uart_state_t     r_state, w_state_nxt;
    logic [BYTE-1:0] r_shift, w_shift_nxt;
    logic [BYTE-1:0] r_hold, w_hold_nxt;
    logic            r_hold_full, w_hold_full_nxt;
    logic            r_data_out, w_data_out_nxt;
    logic [BW-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic            w_restart, w_tick, w_accept, w_load;

    uart_baud_gen #(.N(BAUD_DIV), .W(CW)) u_baud (
        .i_clk     (clk),
        .i_areset  (areset),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    assign w_accept = tx_valid && !r_hold_full;
    assign tx_ready = !r_hold_full;
    assign data_out = r_data_out;
    assign tx_busy  = (r_state != IDLE);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_data_out  <= LINE_IDLE;
            r_bit_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_data_out  <= w_data_out_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        w_data_out_nxt  = r_data_out;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_restart       = 1'b0;
        w_load          = 1'b0;

        case (r_state)
            IDLE: begin
                w_restart = 1'b1;
                w_load    = r_hold_full;
            end
            START: begin
                if (w_tick) begin
                    w_state_nxt    = DATA;
                    w_data_out_nxt = r_shift[0];
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt == LAST_DATA) begin
                        w_state_nxt    = STOP;
                        w_data_out_nxt = STOP_BIT;
                        w_bit_cnt_nxt  = '0;
                    end else begin
                        w_shift_nxt    = r_shift >> 1;
                        w_data_out_nxt = w_shift_nxt[0];
                        w_bit_cnt_nxt  = r_bit_cnt + BW'(1);
                    end
                end
            end
            STOP: begin
                // Bit counter is reused to count stop-bit periods.
                if (w_tick) begin
                    if (r_bit_cnt == LAST_STOP) begin
                        if (r_hold_full) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_data_out_nxt = LINE_IDLE;
            end
        endcase

        // Frame start, shared by the IDLE exit and the back-to-back STOP exit.
        if (w_load) begin
            w_state_nxt     = START;
            w_shift_nxt     = r_hold;
            w_hold_full_nxt = 1'b0;
            w_data_out_nxt  = START_BIT;
            w_bit_cnt_nxt   = '0;
            w_restart       = 1'b1;
        end

        if (w_accept) begin
            w_hold_nxt      = tx_data;
            w_hold_full_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model plus a line receiver.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int unsigned DIV = 16;

    logic       clk = 1'b0;
    logic       areset = 1'b1;
    logic       f_valid = 1'b0;
    logic [7:0] f_data = '0;
    logic       sel2 = 1'b0;

    logic tx_valid, tx2_valid, tx_ready, tx2_ready;
    logic data_out, data_out2, tx_busy, tx2_busy;
    logic rdy, rx_line;

    assign tx_valid  = f_valid && !sel2;
    assign tx2_valid = f_valid && sel2;
    assign rdy       = sel2 ? tx2_ready : tx_ready;
    assign rx_line   = sel2 ? data_out2 : data_out;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] src_q[$];
    logic [7:0] exp_rx[$];
    int unsigned acc_cyc[$];

    uart_tx #(.CLK_FRQ(16), .BAUD_RATE(1), .BYTE(8), .STOP_BITS(1)) dut (
        .clk(clk), .areset(areset), .tx_valid(tx_valid), .tx_data(f_data),
        .tx_ready(tx_ready), .data_out(data_out), .tx_busy(tx_busy)
    );

    uart_tx #(.CLK_FRQ(16), .BAUD_RATE(1), .BYTE(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .areset(areset), .tx_valid(tx2_valid), .tx_data(f_data),
        .tx_ready(tx2_ready), .data_out(data_out2), .tx_busy(tx2_busy)
    );

    // Reference: a queue of per-clock line levels; a held byte becomes a frame
    // as soon as the previous frame's levels are used up.
    logic       m_q[$];
    logic [7:0] m_hold = '0;
    bit         m_full = 0;
    logic       m_line = 1'b1, m_ready = 1'b1, m_busy = 1'b0;

    always @(posedge clk or posedge areset) begin
        bit acc;
        if (areset) begin
            m_q.delete();
            m_full  = 0;
            m_line  = 1'b1;
            m_ready = 1'b1;
            m_busy  = 1'b0;
        end else begin
            acc = tx_valid && !m_full;
            if (m_q.size() == 0 && m_full) begin
                for (int i = 0; i < 10; i++) begin
                    logic lv;
                    lv = (i == 0) ? 1'b0 : (i <= 8) ? m_hold[i-1] : 1'b1;
                    repeat (DIV) m_q.push_back(lv);
                end
                m_full = 0;
            end
            if (acc) begin
                m_hold = tx_data_w();
                m_full = 1;
            end
            if (m_q.size() > 0) begin
                m_line = m_q.pop_front();
                m_busy = 1'b1;
            end else begin
                m_line = 1'b1;
                m_busy = 1'b0;
            end
            m_ready = !m_full;
        end
    end

    function automatic logic [7:0] tx_data_w();
        return f_data;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_step(input bit junk);
        bit acc;
        if (src_q.size() > 0) begin
            f_valid = 1'b1;
            f_data  = (rdy || !junk) ? src_q[0] : 8'($urandom);
            acc     = rdy;
        end else begin
            f_valid = 1'b0;
            acc     = 0;
        end
        step();
        if (acc) begin
            void'(src_q.pop_front());
            acc_cyc.push_back(cyc);
        end
    endtask

    task automatic test_reset();
        int toggles = 0;
        logic prev;
        areset = 1'b1;
        step();
        step();
        areset = 1'b0;
        prev = data_out;
        for (int i = 0; i < 100; i++) begin
            feed_step(0);
            if (data_out !== prev) toggles++;
            prev = data_out;
            n_cmp++; if (data_out !== 1'b1) begin n_bad++; $display("FAIL idle_line i=%0d got %b want 1", i, data_out); end
            n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready i=%0d got %b want 1", i, tx_ready); end
            n_cmp++; if (tx_busy !== 1'b0)  begin n_bad++; $display("FAIL idle_busy i=%0d got %b want 0", i, tx_busy); end
        end
        n_cmp++; if (toggles != 0) begin n_bad++; $display("FAIL idle_toggles got %0d want 0", toggles); end
    endtask

    task automatic test_mid_reset();
        src_q.push_back(8'($urandom));
        repeat (50) feed_step(0);
        n_cmp++; if (tx_busy !== m_busy) begin n_bad++; $display("FAIL pre_reset_busy got %b want %b", tx_busy, m_busy); end
        #2;
        areset = 1'b1;
        #1;
        n_cmp++; if (data_out !== 1'b1) begin n_bad++; $display("FAIL async_line got %b want 1", data_out); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL async_ready got %b want 1", tx_ready); end
        n_cmp++; if (tx_busy !== 1'b0)  begin n_bad++; $display("FAIL async_busy got %b want 0", tx_busy); end
        step();
        areset = 1'b0;
        src_q.push_back(8'h3C);
        for (int i = 0; i < 175; i++) begin
            feed_step(0);
            n_cmp++; if (data_out !== m_line)  begin n_bad++; $display("FAIL rst3c_line i=%0d got %b want %b", i, data_out, m_line); end
            n_cmp++; if (tx_ready !== m_ready) begin n_bad++; $display("FAIL rst3c_ready i=%0d got %b want %b", i, tx_ready, m_ready); end
            n_cmp++; if (tx_busy !== m_busy)   begin n_bad++; $display("FAIL rst3c_busy i=%0d got %b want %b", i, tx_busy, m_busy); end
        end
    endtask

    task automatic test_single();
        logic [9:0] pat;
        int busy_n = 0;
        int unsigned fall = 0;
        bit seen = 0;
        pat = 10'b1101001010; // bit 0 is the first level on the line
        acc_cyc.delete();
        src_q.push_back(8'hA5);
        for (int i = 0; i < 175; i++) begin
            feed_step(0);
            if (tx_busy === 1'b1) busy_n++;
            if (!seen && data_out === 1'b0) begin seen = 1; fall = cyc; end
            if (seen && cyc - fall < 160 && (cyc - fall) % DIV == DIV / 2) begin
                n_cmp++;
                if (data_out !== pat[(cyc - fall) / DIV])
                    begin n_bad++; $display("FAIL a5_bit idx=%0d got %b want %b", (cyc - fall) / DIV, data_out, pat[(cyc - fall) / DIV]); end
            end
            n_cmp++; if (data_out !== m_line) begin n_bad++; $display("FAIL a5_line i=%0d got %b want %b", i, data_out, m_line); end
        end
        n_cmp++; if (busy_n != 160) begin n_bad++; $display("FAIL a5_busy_len got %0d want 160", busy_n); end
        n_cmp++; if (acc_cyc.size() != 1 || fall != acc_cyc[0] + 1)
            begin n_bad++; $display("FAIL a5_latency got fall=%0d want %0d", fall, acc_cyc.size() ? acc_cyc[0] + 1 : 0); end
    endtask

    task automatic test_back_to_back();
        int busy_n = 0;
        acc_cyc.delete();
        src_q.push_back(8'h00);
        src_q.push_back(8'hFF);
        for (int i = 0; i < 340; i++) begin
            feed_step(0);
            if (tx_busy === 1'b1) busy_n++;
            n_cmp++; if (data_out !== m_line)  begin n_bad++; $display("FAIL b2b_line i=%0d got %b want %b", i, data_out, m_line); end
            n_cmp++; if (tx_ready !== m_ready) begin n_bad++; $display("FAIL b2b_ready i=%0d got %b want %b", i, tx_ready, m_ready); end
        end
        n_cmp++; if (busy_n != 320) begin n_bad++; $display("FAIL b2b_busy_len got %0d want 320", busy_n); end
        n_cmp++; if (acc_cyc.size() != 2 || acc_cyc[1] - acc_cyc[0] != 2)
            begin n_bad++; $display("FAIL b2b_accept_gap got %0d accepts want 2 with gap 2", acc_cyc.size()); end
        n_cmp++; if (tx_ready !== 1'b1 || tx_busy !== 1'b0)
            begin n_bad++; $display("FAIL b2b_end got ready=%b busy=%b want 1/0", tx_ready, tx_busy); end
    endtask

    task automatic test_stall();
        acc_cyc.delete();
        repeat (3) src_q.push_back(8'($urandom));
        for (int i = 0; i < 520; i++) begin
            feed_step(1);
            n_cmp++; if (data_out !== m_line)  begin n_bad++; $display("FAIL stall_line i=%0d got %b want %b", i, data_out, m_line); end
            n_cmp++; if (tx_ready !== m_ready) begin n_bad++; $display("FAIL stall_ready i=%0d got %b want %b", i, tx_ready, m_ready); end
            n_cmp++; if (tx_busy !== m_busy)   begin n_bad++; $display("FAIL stall_busy i=%0d got %b want %b", i, tx_busy, m_busy); end
        end
        n_cmp++; if (acc_cyc.size() != 3 || acc_cyc[2] - acc_cyc[0] != 2 + 10 * DIV)
            begin n_bad++; $display("FAIL stall_third_accept got %0d accepts want 3 with offset %0d", acc_cyc.size(), 2 + 10 * DIV); end
    endtask

    task automatic rx_frames(input int unsigned nstop, input int unsigned nframes);
        int unsigned last_start = 0;
        logic [7:0] b;
        logic [7:0] want;
        for (int unsigned f = 0; f < nframes; f++) begin
            int unsigned w = 0;
            while (rx_line !== 1'b0 && w < 20 * DIV) begin step(); w++; end
            n_cmp++;
            if (rx_line !== 1'b0) begin n_bad++; $display("FAIL rx_timeout frame=%0d got %b want 0", f, rx_line); return; end
            if (f > 0) begin
                n_cmp++;
                if (cyc - last_start != (1 + 8 + nstop) * DIV)
                    begin n_bad++; $display("FAIL rx_period frame=%0d got %0d want %0d", f, cyc - last_start, (1 + 8 + nstop) * DIV); end
            end
            last_start = cyc;
            repeat (DIV / 2) step();
            n_cmp++; if (rx_line !== 1'b0) begin n_bad++; $display("FAIL rx_start frame=%0d got %b want 0", f, rx_line); end
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) step();
                b[i] = rx_line;
            end
            for (int unsigned s = 0; s < nstop; s++) begin
                repeat (DIV) step();
                n_cmp++; if (rx_line !== 1'b1) begin n_bad++; $display("FAIL rx_stop frame=%0d got %b want 1", f, rx_line); end
            end
            want = exp_rx.pop_front();
            n_cmp++; if (b !== want) begin n_bad++; $display("FAIL rx_data frame=%0d got %h want %h", f, b, want); end
        end
    endtask

    task automatic run_loop(input int unsigned nstop, input int unsigned n);
        fork
            begin
                int guard = 0;
                while (src_q.size() > 0 && guard < 60000) begin feed_step(0); guard++; end
                f_valid = 1'b0;
            end
            rx_frames(nstop, n);
        join
    endtask

    task automatic test_loopback();
        sel2 = 1'b0;
        exp_rx.delete();
        for (int v = 0; v < 256; v++) begin
            src_q.push_back(8'(v));
            exp_rx.push_back(8'(v));
        end
        run_loop(1, 256);
        repeat (2 * DIV) step();
        sel2 = 1'b1;
        exp_rx.delete();
        src_q.delete();
        for (int v = 0; v < 24; v++) begin
            logic [7:0] r;
            r = 8'($urandom);
            src_q.push_back(r);
            exp_rx.push_back(r);
        end
        run_loop(2, 24);
        repeat (2 * DIV) step();
        sel2 = 1'b0;
    endtask

    initial begin
        areset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        areset = 1'b0;
        test_reset();
        test_mid_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serialises parallel bytes onto the UART line as 8N1-style frames: start bit low, BYTE data bits LSB first, STOP_BITS stop bits high.
- Sits directly upstream of the link: its data_out drives the rx line input of the receiver.
- Has a ready/valid byte input and a one-entry holding register, so the next byte can be accepted while the current frame shifts out. Frames are sent back to back with no idle gap.

Parameters:
- CLK_FRQ, 250000000, clock frequency in Hz
- BAUD_RATE, 115200, line bit rate in bits/s
- BYTE, 8, data bits per frame
- STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
- clk  input  1  system clock
- areset  input  1  reset
- tx_valid  input  1  upstream has a byte on tx_data
- tx_data  input  BYTE  byte to transmit
- tx_ready  output  1  holding register empty; byte accepted when tx_valid && tx_ready
- data_out  output  1  serial line, idle high
- tx_busy  output  1  a frame is on the line (state != IDLE)

Behaviour:
- Clock and reset: clk, rising edge; areset, asynchronous, active-high.
- Reset values: data_out=1, tx_ready=1, tx_busy=0, holding register empty, state IDLE, shift register 0.
- Reset mid-frame: data_out returns high immediately (asynchronous); the in-flight byte and the held byte are discarded.
- Bit period: BAUD_DIV = CLK_FRQ/BAUD_RATE clocks, integer division.
  - The baud counter is local and restarts at frame start, so the start bit lasts exactly BAUD_DIV clocks.
  - There is no free-running tick.
- Handshake:
  - Accept on any edge where tx_valid && tx_ready; tx_data is captured into the holding register and hold_full is set.
  - tx_ready = !hold_full, a registered flag; it is not combinational from tx_valid.
  - tx_data is sampled only on the accept edge.
  - With tx_valid high and tx_ready low, upstream stalls and must hold its data.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on the edge after hold_full=1. On that edge: the holding register moves to the shifter, hold_full clears, data_out=0, bit counter=0, baud counter=0.
  - Resulting latency: accept at edge k; data_out falls at edge k+1.
  - START -> DATA after BAUD_DIV clocks; data_out=shifter[0].
  - DATA: every BAUD_DIV clocks, shift right and increment the bit counter. After bit BYTE-1 has been held for BAUD_DIV clocks, go to STOP with data_out=1.
  - STOP lasts STOP_BITS*BAUD_DIV clocks, then:
    - if hold_full: go straight to START, loading as on the IDLE exit (no idle cycles between frames);
    - else: go to IDLE.
- Simultaneous events: accept and hold->shifter transfer cannot coincide, because tx_ready is 0 whenever hold_full is 1. The accept on the edge where hold_full clears is the following cycle.
- tx_busy=1 from the START entry edge until the edge that enters IDLE.
- Frame length: (1+BYTE+STOP_BITS)*BAUD_DIV clocks exactly.
- Counter widths:
  - baud counter is $clog2(STOP_BITS*BAUD_DIV) bits;
  - bit counter is $clog2(BYTE)+1 bits;
  - neither may wrap inside a frame.
- Default state: the encoding space is fully covered; any illegal state returns to IDLE with data_out=1.

Decomposition:
- Shared package uart_pkg, used by both tx and rx:
  - baud_div(clk_frq, baud_rate) function;
  - uart_state_t enum (IDLE/START/DATA/STOP);
  - line levels START_BIT=0, STOP_BIT=1, LINE_IDLE=1.
- One sub-module, uart_baud_gen: restartable counter with a synchronous restart input and a single-cycle tick every N clocks. The receiver can adopt it later.

Test Plan:
All tests use CLK_FRQ=16, BAUD_RATE=1 (BAUD_DIV=16) unless noted.
1. Assert areset mid-DATA -> data_out=1, tx_ready=1 and tx_busy=0 in the same cycle; release areset, send 0x3C -> a correct full frame.
2. Reset, then idle for 100 clocks -> data_out=1, tx_ready=1, tx_busy=0 throughout; no transitions on data_out.
3. Single accept of 0xA5 -> data_out falls one clock after the accept; the line then carries 0,1,0,1,0,0,1,0,1,1, each level held 16 clocks; tx_busy high for 160 clocks.
4. tx_valid held high with 0x00 then 0xFF -> second accept occurs the cycle after the first frame starts; 20 consecutive bit periods (320 clocks) with no idle gap; then tx_ready=1 and tx_busy=0.
5. Three bytes offered back to back -> tx_valid stalls with tx_ready=0 until the second frame starts; byte order on the line is preserved; tx_data changes during the stall are ignored until accept.
6. Loopback data_out into the receiver with default parameters, sending all 256 values -> the receiver reports each value once, in order, with no framing drop; repeat with STOP_BITS=2 and check each frame is 11 bit periods.
